// File: rtl/datapath_controller.sv
// Instruction-sequencing controller for the register file / A-B-C load datapath.
// Latches one instruction per start handshake and steps it through Moore control states.
module datapath_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        loadc,
    output logic        loads,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic       is_mov;
    logic       is_alu;
    logic       mov_imm;
    logic       mov_reg;
    logic       is_mvn;
    logic       is_cmp;

    assign opcode  = ir[15:13];
    assign op      = ir[12:11];
    assign rn      = ir[10:8];
    assign rd      = ir[7:5];
    assign rm      = ir[2:0];
    assign is_mov  = (opcode == 3'b110);
    assign is_alu  = (opcode == 3'b101);
    assign mov_imm = is_mov && (op == 2'b10);
    assign mov_reg = is_mov && (op == 2'b00);
    assign is_mvn  = is_alu && (op == 2'b11);
    assign is_cmp  = is_alu && (op == 2'b01);

    // MOV always routes through the ALU as a pass-through add.
    assign ALUop  = is_mov ? 2'b00 : op;
    assign shift  = ir[4:3];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_WAIT && s) begin
                ir <= in;
            end
        end
    end

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        next_state = state;
        w          = 1'b0;
        readnum    = 3'd0;
        writenum   = 3'd0;
        write      = 1'b0;
        vsel       = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        asel       = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) next_state = S_DECODE;
            end
            S_DECODE: begin
                if (mov_imm)                 next_state = S_WRITE_IMM;
                else if (is_alu && !is_mvn)  next_state = S_GET_A;
                else if (mov_reg || is_mvn)  next_state = S_GET_B;
                else                         next_state = S_WAIT;
            end
            S_WRITE_IMM: begin
                write      = 1'b1;
                vsel       = 1'b1;
                writenum   = rn;
                next_state = S_WAIT;
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = S_GET_B;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = S_EXEC;
            end
            S_EXEC: begin
                // Single-operand forms zero the A input so the ALU sees only B.
                asel = mov_reg || is_mvn;
                if (is_cmp) begin
                    loads      = 1'b1;
                    next_state = S_WAIT;
                end else begin
                    loadc      = 1'b1;
                    next_state = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                write      = 1'b1;
                writenum   = rd;
                next_state = S_WAIT;
            end
            default: next_state = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller: walks each instruction class state by state
// against hand-decoded expected control vectors.
module tb_datapath_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        loadc;
    logic        loads;
    logic [1:0]  ALUop;
    logic [1:0]  shift;
    logic [15:0] sximm8;

    int total = 0;
    int bad   = 0;

    datapath_controller dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .in       (in),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .asel     (asel),
        .loadc    (loadc),
        .loads    (loads),
        .ALUop    (ALUop),
        .shift    (shift),
        .sximm8   (sximm8)
    );

    always #5 clk = ~clk;

    // Packed view: {w, readnum, writenum, write, vsel, loada, loadb, asel, loadc, loads}
    logic [13:0] ctl;
    assign ctl = {w, readnum, writenum, write, vsel, loada, loadb, asel, loadc, loads};

    function automatic logic [13:0] exp_ctl(input logic ew, input logic [2:0] ern,
                                            input logic [2:0] ewn, input logic ewr,
                                            input logic evs, input logic ela,
                                            input logic elb, input logic eas,
                                            input logic elc, input logic els);
        return {ew, ern, ewn, ewr, evs, ela, elb, eas, elc, els};
    endfunction

    localparam logic [13:0] IDLE = 14'b1_000_000_0000000;
    localparam logic [13:0] BUSY = 14'b0_000_000_0000000;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        s     = 1'b0;
        in    = 16'h0000;
        tick();
        check("reset_ctl", {2'b0, ctl}, {2'b0, IDLE});
        check("reset_sximm8", sximm8, 16'h0000);
        check("reset_aluop", {14'b0, ALUop}, 16'h0000);
        #2 reset = 1'b0;

        // MOV R1,#-5
        s  = 1'b1;
        in = 16'hD1FB;
        tick();
        s = 1'b0;
        check("movi_decode", {2'b0, ctl}, {2'b0, BUSY});
        check("movi_sximm8", sximm8, 16'hFFFB);
        check("movi_shift", {14'b0, shift}, 16'd3);
        check("movi_aluop_forced", {14'b0, ALUop}, 16'd0);
        tick();
        check("movi_write_imm", {2'b0, ctl}, {2'b0, exp_ctl(0, 0, 1, 1, 1, 0, 0, 0, 0, 0)});
        tick();
        check("movi_back_to_wait", {2'b0, ctl}, {2'b0, IDLE});

        // ADD R2,R1,R0 LSL#1 with a stray start pulse mid-instruction
        s  = 1'b1;
        in = 16'hA148;
        tick();
        s  = 1'b0;
        in = 16'hE000;
        check("add_decode", {2'b0, ctl}, {2'b0, BUSY});
        tick();
        check("add_get_a", {2'b0, ctl}, {2'b0, exp_ctl(0, 1, 0, 0, 0, 1, 0, 0, 0, 0)});
        s = 1'b1;
        tick();
        s = 1'b0;
        check("add_get_b", {2'b0, ctl}, {2'b0, exp_ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)});
        check("add_ir_kept", sximm8, 16'h0048);
        tick();
        check("add_exec", {2'b0, ctl}, {2'b0, exp_ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
        check("add_shift", {14'b0, shift}, 16'd1);
        check("add_aluop", {14'b0, ALUop}, 16'd0);
        tick();
        check("add_write_reg", {2'b0, ctl}, {2'b0, exp_ctl(0, 0, 2, 1, 0, 0, 0, 0, 0, 0)});
        tick();
        check("add_back_to_wait", {2'b0, ctl}, {2'b0, IDLE});

        // CMP R1,R0 then MVN R3,R0 back-to-back with s held high
        s  = 1'b1;
        in = 16'hA900;
        tick();
        in = 16'hB860;
        check("cmp_decode", {2'b0, ctl}, {2'b0, BUSY});
        check("cmp_ir_kept", sximm8, 16'h0000);
        tick();
        check("cmp_get_a", {2'b0, ctl}, {2'b0, exp_ctl(0, 1, 0, 0, 0, 1, 0, 0, 0, 0)});
        tick();
        check("cmp_get_b", {2'b0, ctl}, {2'b0, exp_ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)});
        tick();
        check("cmp_exec", {2'b0, ctl}, {2'b0, exp_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
        check("cmp_aluop", {14'b0, ALUop}, 16'd1);
        tick();
        check("cmp_wait_one_cycle", {2'b0, ctl}, {2'b0, IDLE});
        tick();
        s = 1'b0;
        check("mvn_decode", {2'b0, ctl}, {2'b0, BUSY});
        check("mvn_sximm8", sximm8, 16'h0060);
        tick();
        check("mvn_get_b", {2'b0, ctl}, {2'b0, exp_ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)});
        tick();
        check("mvn_exec", {2'b0, ctl}, {2'b0, exp_ctl(0, 0, 0, 0, 0, 0, 0, 1, 1, 0)});
        check("mvn_aluop", {14'b0, ALUop}, 16'd3);
        tick();
        check("mvn_write_reg", {2'b0, ctl}, {2'b0, exp_ctl(0, 0, 3, 1, 0, 0, 0, 0, 0, 0)});
        tick();
        check("mvn_back_to_wait", {2'b0, ctl}, {2'b0, IDLE});

        // MOV R5,R1,LSR (sh=10)
        s  = 1'b1;
        in = 16'hC0B1;
        tick();
        s = 1'b0;
        check("movr_decode", {2'b0, ctl}, {2'b0, BUSY});
        tick();
        check("movr_get_b", {2'b0, ctl}, {2'b0, exp_ctl(0, 1, 0, 0, 0, 0, 1, 0, 0, 0)});
        tick();
        check("movr_exec", {2'b0, ctl}, {2'b0, exp_ctl(0, 0, 0, 0, 0, 0, 0, 1, 1, 0)});
        check("movr_shift", {14'b0, shift}, 16'd2);
        tick();
        check("movr_write_reg", {2'b0, ctl}, {2'b0, exp_ctl(0, 0, 5, 1, 0, 0, 0, 0, 0, 0)});
        tick();
        check("movr_back_to_wait", {2'b0, ctl}, {2'b0, IDLE});

        // Invalid encoding: single busy cycle, no strobes
        s  = 1'b1;
        in = 16'hE000;
        tick();
        s = 1'b0;
        check("inv_decode", {2'b0, ctl}, {2'b0, BUSY});
        tick();
        check("inv_back_to_wait", {2'b0, ctl}, {2'b0, IDLE});

        // Reset during GET_B of an ADD
        s  = 1'b1;
        in = 16'hA148;
        tick();
        s = 1'b0;
        tick();
        tick();
        check("rst_pre_get_b", {2'b0, ctl}, {2'b0, exp_ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)});
        #2 reset = 1'b1;
        #1;
        check("rst_async_wait", {2'b0, ctl}, {2'b0, IDLE});
        check("rst_ir_cleared", sximm8, 16'h0000);
        tick();
        check("rst_held_wait", {2'b0, ctl}, {2'b0, IDLE});
        #2;
        reset = 1'b0;
        s     = 1'b1;
        in    = 16'hD1FB;
        tick();
        s = 1'b0;
        check("rst_new_accept", {2'b0, ctl}, {2'b0, BUSY});
        check("rst_new_sximm8", sximm8, 16'hFFFB);
        tick();
        check("rst_new_write_imm", {2'b0, ctl}, {2'b0, exp_ctl(0, 0, 1, 1, 1, 0, 0, 0, 0, 0)});
        tick();
        check("rst_new_wait", {2'b0, ctl}, {2'b0, IDLE});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
